// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state encoding, datapath select codes and control word for the multicycle MIPS control unit
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADR  = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JAL      = 4'd11,
        S_IMM_EXEC = 4'd12,
        S_IMM_WB   = 4'd13
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] TOREG_ALUOUT = 2'b00;
    localparam logic [1:0] TOREG_MDR    = 2'b01;
    localparam logic [1:0] TOREG_PC     = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_toreg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       logic_ext;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // State that follows DECODE; S_FETCH marks an unknown or build-disabled opcode.
    function automatic state_t decode_next(input logic [5:0] op, input bit has_jal, input bit has_imm);
        state_t nxt;
        nxt = S_FETCH;
        case (op)
            OP_RTYPE:        nxt = S_R_EXEC;
            OP_LW, OP_SW:    nxt = S_MEM_ADR;
            OP_BEQ:          nxt = S_BRANCH;
            OP_J:            nxt = S_JUMP;
            OP_JAL:          nxt = has_jal ? S_JAL : S_FETCH;
            OP_ADDI, OP_ORI: nxt = has_imm ? S_IMM_EXEC : S_FETCH;
            default:         nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - combinational state/opcode/mem_ready to control word decode
// Ports: state (current FSM state), opcode (IR[31:26]), mem_rdy (effective memory
// ready, already forced high when waits are disabled), ctrl (full control word).
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
#(
    parameter bit HAS_JAL = 1'b1,
    parameter bit HAS_IMM = 1'b1
) (
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_rdy,
    output ctrl_t      ctrl
);

    logic is_ori;
    assign is_ori = (opcode == OP_ORI);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                // IR and PC+4 are only captured on the cycle memory delivers.
                ctrl.ir_write  = mem_rdy;
                ctrl.pc_write  = mem_rdy;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALU_ADD;
                ctrl.illegal   = (decode_next(opcode, HAS_JAL, HAS_IMM) == S_FETCH);
            end
            S_MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_toreg  = TOREG_MDR;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_rdy;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_dst    = REGDST_RD;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                // r31 gets the PC already advanced in FETCH, written on the same edge as the jump.
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_R31;
                ctrl.mem_toreg  = TOREG_PC;
                ctrl.instr_done = 1'b1;
            end
            S_IMM_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_IMM;
                ctrl.logic_ext = is_ori;
            end
            S_IMM_WB: begin
                ctrl.reg_dst    = REGDST_RT;
                ctrl.reg_write  = 1'b1;
                ctrl.logic_ext  = is_ori;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controlunit.sv
// rtl/multicycle_controlunit.sv - multicycle MIPS main control FSM with memory-ready wait
// Ports: clk, reset (async active-high), opcode (IR[31:26]), mem_ready (memory access
// completes this cycle); outputs are the datapath control strobes/selects, instr_done
// and illegal pulses, and the current state for debug. logic_ext selects zero-extension
// of the immediate (ori).
module multicycle_controlunit
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b1,
    parameter bit HAS_JAL  = 1'b1,
    parameter bit HAS_IMM  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_toreg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       logic_ext,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    logic   mem_rdy;
    ctrl_t  ctrl;

    assign mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_rdy) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next(opcode, HAS_JAL, HAS_IMM);
            // Only lw and sw reach MEM_ADR.
            S_MEM_ADR:  state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_rdy) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_rdy) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_ALU_WB;
            S_IMM_EXEC: state_d = S_IMM_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JAL, S_IMM_WB: state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    mips_ctrl_outdec #(
        .HAS_JAL (HAS_JAL),
        .HAS_IMM (HAS_IMM)
    ) u_outdec (
        .state   (state_q),
        .opcode  (opcode),
        .mem_rdy (mem_rdy),
        .ctrl    (ctrl)
    );

    assign pc_write   = ctrl.pc_write;
    assign branch     = ctrl.branch;
    assign pc_src     = ctrl.pc_src;
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_toreg  = ctrl.mem_toreg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign logic_ext  = ctrl.logic_ext;
    assign instr_done = ctrl.instr_done;
    assign illegal    = ctrl.illegal;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controlunit.sv
// tb/tb_multicycle_controlunit.sv - directed self-checking bench for multicycle_controlunit
module tb_multicycle_controlunit;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADR  = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_R_EXEC   = 4'd7;
    localparam logic [3:0] S_ALU_WB   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_IMM_EXEC = 4'd12;
    localparam logic [3:0] S_IMM_WB   = 4'd13;

    // Observed word: {pc_write, branch, pc_src, i_or_d, mem_read, mem_write, ir_write,
    // reg_write, reg_dst, mem_toreg, alu_src_a, alu_src_b, alu_op, logic_ext, instr_done, illegal}
    localparam logic [20:0] B_PCW  = 21'd1 << 20;
    localparam logic [20:0] B_BR   = 21'd1 << 19;
    localparam logic [20:0] B_IORD = 21'd1 << 16;
    localparam logic [20:0] B_MR   = 21'd1 << 15;
    localparam logic [20:0] B_MW   = 21'd1 << 14;
    localparam logic [20:0] B_IRW  = 21'd1 << 13;
    localparam logic [20:0] B_RW   = 21'd1 << 12;
    localparam logic [20:0] B_ASA  = 21'd1 << 7;
    localparam logic [20:0] B_LOG  = 21'd1 << 2;
    localparam logic [20:0] B_DONE = 21'd1 << 1;
    localparam logic [20:0] B_ILL  = 21'd1;

    localparam logic [20:0] E_FETCH      = B_PCW | B_MR | B_IRW | (21'd1 << 5);
    localparam logic [20:0] E_FETCH_WAIT = B_MR | (21'd1 << 5);
    localparam logic [20:0] E_DECODE     = 21'd3 << 5;
    localparam logic [20:0] E_ILL        = E_DECODE | B_ILL;
    localparam logic [20:0] E_MEM_ADR    = B_ASA | (21'd2 << 5);
    localparam logic [20:0] E_MEM_RD     = B_IORD | B_MR;
    localparam logic [20:0] E_MEM_WB     = (21'd1 << 8) | B_RW | B_DONE;
    localparam logic [20:0] E_MEM_WR     = B_IORD | B_MW | B_DONE;
    localparam logic [20:0] E_R_EXEC     = B_ASA | (21'd2 << 3);
    localparam logic [20:0] E_ALU_WB     = (21'd1 << 10) | B_RW | B_DONE;
    localparam logic [20:0] E_BRANCH     = B_ASA | (21'd1 << 3) | (21'd1 << 17) | B_BR | B_DONE;
    localparam logic [20:0] E_JUMP       = (21'd2 << 17) | B_PCW | B_DONE;
    localparam logic [20:0] E_JAL        = E_JUMP | B_RW | (21'd2 << 10) | (21'd2 << 8);
    localparam logic [20:0] E_IMM_EXEC   = B_ASA | (21'd2 << 5) | (21'd3 << 3);
    localparam logic [20:0] E_IMM_WB     = B_RW | B_DONE;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mr;
    logic       mr_tied0;

    logic       pc_write   [3];
    logic       branch     [3];
    logic [1:0] pc_src     [3];
    logic       i_or_d     [3];
    logic       mem_read   [3];
    logic       mem_write  [3];
    logic       ir_write   [3];
    logic       reg_write  [3];
    logic [1:0] reg_dst    [3];
    logic [1:0] mem_toreg  [3];
    logic       alu_src_a  [3];
    logic [1:0] alu_src_b  [3];
    logic [1:0] alu_op     [3];
    logic       logic_ext  [3];
    logic       instr_done [3];
    logic       illegal    [3];
    logic [3:0] st         [3];
    logic [20:0] word      [3];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mr_tied0 = 1'b0;

    // 0: default build, 1: no memory wait (mem_ready tied low), 2: jal and immediates disabled
    multicycle_controlunit #(.MEM_WAIT(1'b1), .HAS_JAL(1'b1), .HAS_IMM(1'b1)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mr),
        .pc_write(pc_write[0]), .branch(branch[0]), .pc_src(pc_src[0]), .i_or_d(i_or_d[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .ir_write(ir_write[0]),
        .reg_write(reg_write[0]), .reg_dst(reg_dst[0]), .mem_toreg(mem_toreg[0]),
        .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]), .alu_op(alu_op[0]),
        .logic_ext(logic_ext[0]), .instr_done(instr_done[0]), .illegal(illegal[0]), .state(st[0])
    );

    multicycle_controlunit #(.MEM_WAIT(1'b0), .HAS_JAL(1'b1), .HAS_IMM(1'b1)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mr_tied0),
        .pc_write(pc_write[1]), .branch(branch[1]), .pc_src(pc_src[1]), .i_or_d(i_or_d[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .ir_write(ir_write[1]),
        .reg_write(reg_write[1]), .reg_dst(reg_dst[1]), .mem_toreg(mem_toreg[1]),
        .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]), .alu_op(alu_op[1]),
        .logic_ext(logic_ext[1]), .instr_done(instr_done[1]), .illegal(illegal[1]), .state(st[1])
    );

    multicycle_controlunit #(.MEM_WAIT(1'b1), .HAS_JAL(1'b0), .HAS_IMM(1'b0)) dut2 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mr),
        .pc_write(pc_write[2]), .branch(branch[2]), .pc_src(pc_src[2]), .i_or_d(i_or_d[2]),
        .mem_read(mem_read[2]), .mem_write(mem_write[2]), .ir_write(ir_write[2]),
        .reg_write(reg_write[2]), .reg_dst(reg_dst[2]), .mem_toreg(mem_toreg[2]),
        .alu_src_a(alu_src_a[2]), .alu_src_b(alu_src_b[2]), .alu_op(alu_op[2]),
        .logic_ext(logic_ext[2]), .instr_done(instr_done[2]), .illegal(illegal[2]), .state(st[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_word
        assign word[g] = {pc_write[g], branch[g], pc_src[g], i_or_d[g], mem_read[g],
                          mem_write[g], ir_write[g], reg_write[g], reg_dst[g], mem_toreg[g],
                          alu_src_a[g], alu_src_b[g], alu_op[g], logic_ext[g],
                          instr_done[g], illegal[g]};
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int d, input logic [3:0] es, input logic [20:0] ew);
        checks++;
        assert (st[d] === es) else begin
            errors++;
            $error("FAIL %s dut%0d state: observed %0d expected %0d", tag, d, st[d], es);
        end
        checks++;
        assert (word[d] === ew) else begin
            errors++;
            $error("FAIL %s dut%0d ctrl: observed %06h expected %06h", tag, d, word[d], ew);
        end
    endtask

    task automatic restart();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        next_cycle();
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'b000000;
        mr     = 1'b1;
        next_cycle();
        chk("reset", 0, S_IDLE, 21'd0);
        chk("reset", 1, S_IDLE, 21'd0);
        chk("reset", 2, S_IDLE, 21'd0);
        reset = 1'b0;
        next_cycle();
        chk("first_fetch", 0, S_FETCH, E_FETCH);

        mr = 1'b0; #1;
        chk("fetch_wait", 0, S_FETCH, E_FETCH_WAIT);
        next_cycle();
        chk("fetch_hold", 0, S_FETCH, E_FETCH_WAIT);
        mr = 1'b1; #1;
        chk("fetch_go", 0, S_FETCH, E_FETCH);

        // R-type
        next_cycle(); chk("r_decode", 0, S_DECODE, E_DECODE);
        next_cycle(); chk("r_exec",   0, S_R_EXEC, E_R_EXEC);
        next_cycle(); chk("r_wb",     0, S_ALU_WB, E_ALU_WB);
        next_cycle(); chk("r_fetch",  0, S_FETCH,  E_FETCH);

        // lw with two wait cycles in MEM_RD
        opcode = 6'b100011;
        next_cycle(); chk("lw_decode", 0, S_DECODE,  E_DECODE);
        next_cycle(); chk("lw_adr",    0, S_MEM_ADR, E_MEM_ADR);
        next_cycle(); mr = 1'b0; #1;
        chk("lw_rd_w1", 0, S_MEM_RD, E_MEM_RD);
        next_cycle(); chk("lw_rd_w2", 0, S_MEM_RD, E_MEM_RD);
        mr = 1'b1; #1;
        chk("lw_rd_go", 0, S_MEM_RD, E_MEM_RD);
        next_cycle(); chk("lw_wb",    0, S_MEM_WB, E_MEM_WB);
        next_cycle(); chk("lw_fetch", 0, S_FETCH,  E_FETCH);

        // Reset asserted in the middle of MEM_RD
        next_cycle(); chk("rst_decode", 0, S_DECODE,  E_DECODE);
        next_cycle(); chk("rst_adr",    0, S_MEM_ADR, E_MEM_ADR);
        next_cycle(); mr = 1'b0; #1;
        chk("rst_rd", 0, S_MEM_RD, E_MEM_RD);
        reset = 1'b1; #1;
        chk("rst_async", 0, S_IDLE, 21'd0);
        #1; reset = 1'b0; mr = 1'b1;
        next_cycle(); chk("rst_fetch", 0, S_FETCH, E_FETCH);

        // beq
        opcode = 6'b000100;
        next_cycle(); chk("beq_decode", 0, S_DECODE, E_DECODE);
        next_cycle(); chk("beq_branch", 0, S_BRANCH, E_BRANCH);
        next_cycle(); chk("beq_fetch",  0, S_FETCH,  E_FETCH);

        // j
        opcode = 6'b000010;
        next_cycle(); chk("j_decode", 0, S_DECODE, E_DECODE);
        next_cycle(); chk("j_jump",   0, S_JUMP,   E_JUMP);
        next_cycle(); chk("j_fetch",  0, S_FETCH,  E_FETCH);

        // sw on the no-wait build with mem_ready tied low
        restart();
        opcode = 6'b101011;
        chk("sw_fetch",  1, S_FETCH, E_FETCH);
        next_cycle(); chk("sw_decode", 1, S_DECODE,  E_DECODE);
        next_cycle(); chk("sw_adr",    1, S_MEM_ADR, E_MEM_ADR);
        next_cycle(); chk("sw_wr",     1, S_MEM_WR,  E_MEM_WR);
        next_cycle(); chk("sw_done",   1, S_FETCH,   E_FETCH);

        // jal, enabled and disabled
        restart();
        opcode = 6'b000011;
        next_cycle();
        chk("jal_decode",    0, S_DECODE, E_DECODE);
        chk("jal_off_dec",   2, S_DECODE, E_ILL);
        next_cycle();
        chk("jal_exec",      0, S_JAL,    E_JAL);
        chk("jal_off_fetch", 2, S_FETCH,  E_FETCH);
        next_cycle();
        chk("jal_fetch",     0, S_FETCH,  E_FETCH);

        // ori then addi
        restart();
        opcode = 6'b001101;
        next_cycle(); chk("ori_decode", 0, S_DECODE,   E_DECODE);
        next_cycle(); chk("ori_exec",   0, S_IMM_EXEC, E_IMM_EXEC | B_LOG);
        next_cycle(); chk("ori_wb",     0, S_IMM_WB,   E_IMM_WB | B_LOG);
        next_cycle(); chk("ori_fetch",  0, S_FETCH,    E_FETCH);

        restart();
        opcode = 6'b001000;
        next_cycle();
        chk("addi_decode",     0, S_DECODE,   E_DECODE);
        chk("addi_off_dec",    2, S_DECODE,   E_ILL);
        next_cycle();
        chk("addi_exec",       0, S_IMM_EXEC, E_IMM_EXEC);
        chk("addi_off_fetch",  2, S_FETCH,    E_FETCH);
        next_cycle(); chk("addi_wb",    0, S_IMM_WB, E_IMM_WB);
        next_cycle(); chk("addi_fetch", 0, S_FETCH,  E_FETCH);

        // unknown opcode
        restart();
        opcode = 6'b111111;
        next_cycle(); chk("ill_decode", 0, S_DECODE, E_ILL);
        next_cycle(); chk("ill_fetch",  0, S_FETCH,  E_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controlunit.md
Name: multicycle_controlunit

Overview:
- Multicycle MIPS main control: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, instead of producing a single-cycle decode.
- Sits between the instruction register (supplies opcode) and the shared datapath: PC, unified memory, register file, ALU and its decoder.
- Adds a memory-ready wait handshake and build-time instruction-subset modes.

Parameters:
- MEM_WAIT, 1: when 1, FETCH, MEM_RD and MEM_WR stall until mem_ready=1; when 0, mem_ready is ignored and treated as 1.
- HAS_JAL, 1: when 0, opcode 000011 is illegal.
- HAS_IMM, 1: when 0, opcodes 001000 (addi) and 001101 (ori) are illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  IR[31:26]; stable from DECODE until the instruction's last state.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- branch  out  1  PC load if ALU zero.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- reg_write  out  1  register file write.
- reg_dst  out  2  00 rt, 01 rd, 10 r31.
- mem_toreg  out  2  00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  1  0 PC, 1 A.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign/zero-ext imm, 11 imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 funct, 11 immediate.
- logic  out  1  zero-extend imm (ori).
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal  out  1  one-cycle pulse in DECODE on an unknown/disabled opcode.
- state  out  4  current state, for debug.

Behaviour:
- States (4-bit): IDLE, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, ALU_WB, BRANCH, JUMP, JAL, IMM_EXEC, IMM_WB.
- Moore outputs decoded from the state register only, except the mem_ready gating listed below. Every output not listed for a state is 0; outputs never drive X.
- Reset (async, any time, including mid-instruction): state=IDLE immediately; all outputs 0.
  - First clk edge with reset low: IDLE->FETCH.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00.
  - ir_write=pc_write=mem_ready.
  - Goes to DECODE when mem_ready, else holds.
- DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 / 101011 -> MEM_ADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 000011 -> JAL
  - 001000 / 001101 -> IMM_EXEC
  - anything else, or disabled by parameter: illegal=1, -> FETCH (instruction skipped; PC already advanced).
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00. -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: i_or_d=1, mem_read=1. Holds until mem_ready, then -> MEM_WB.
- MEM_WB: reg_dst=00, mem_toreg=01, reg_write=1, instr_done=1. -> FETCH.
- MEM_WR: i_or_d=1, mem_write=1, held while waiting.
  - instr_done=mem_ready.
  - -> FETCH when mem_ready.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> ALU_WB.
- ALU_WB: reg_dst=01, reg_write=1, instr_done=1. -> FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1, instr_done=1. -> FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1. -> FETCH.
- JAL: pc_src=10, pc_write=1, reg_write=1, reg_dst=10, mem_toreg=10, instr_done=1. -> FETCH.
  - PC written to r31 in the same edge, so it carries the already-incremented PC.
- IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11, logic=(opcode==001101). -> IMM_WB.
- IMM_WB: reg_dst=00, reg_write=1, logic held, instr_done=1. -> FETCH.
- Cycle counts with zero wait, FETCH through last state:
  - beq, j, jal: 3
  - R, sw, addi, ori: 4
  - lw: 5
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds 1.
- Strobe exclusivity: mem_write and reg_write are never both 1. pc_write and branch are never both 1.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants
  - state enum/localparams
  - alu_op, pc_src, alu_src_b, reg_dst and mem_toreg codes
- One natural sub-module: mips_ctrl_outdec, a combinational state+opcode+mem_ready -> control-word decode.
- The top keeps the state register and next-state logic.

Test Plan:
- Reset pulse mid-MEM_RD -> same cycle state=IDLE and all outputs 0; one edge after release state=FETCH.
- R-type (opcode 000000), mem_ready=1 -> states FETCH, DECODE, R_EXEC, ALU_WB; reg_dst=01 and reg_write=1 only in ALU_WB; instr_done at cycle 4.
- lw (100011), mem_ready low 2 cycles in MEM_RD -> 7 cycles total; mem_read and i_or_d held high; reg_write=1 with mem_toreg=01 once.
- sw (101011), MEM_WAIT=0 with mem_ready tied 0 -> completes in 4 cycles; mem_write high exactly 1 cycle.
- jal (000011) -> cycle 3 has pc_write=1, pc_src=10, reg_dst=10, mem_toreg=10, reg_write=1. Same opcode with HAS_JAL=0 -> illegal pulse in DECODE, next state FETCH, no reg_write.
- ori (001101) vs addi (001000) -> logic=1 vs 0 in IMM_EXEC and IMM_WB; alu_op=11 in both; opcode 111111 -> illegal=1, no write strobes.
